// File: rtl/approx_error_monitor_pkg.sv
// Shared types, default widths and helpers for the approximate-multiplier error monitor.
package approx_mon_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned P_W_DEF    = 16;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned SAT_W      = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    // Unsigned add clamped to the all-ones value of a width-bit field.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                                 input logic [SAT_W-1:0] inc,
                                                 input int unsigned      width);
        logic [SAT_W-1:0] lim;
        logic [SAT_W:0]   sum;
        lim = (SAT_W'(1) << width) - SAT_W'(1);
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > {1'b0, lim}) return lim;
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/approx_error_monitor_if.sv
// Sample stream, window control and result readout of the error monitor.
interface approx_error_monitor_if
    import approx_mon_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned P_W    = P_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
);
    logic              start;
    logic [CNT_W-1:0]  num_samples;
    logic              in_valid;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [P_W-1:0]    p_approx;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  err_count;
    logic [ACC_W-1:0]  sum_ed;
    logic [P_W-1:0]    max_ed;
    logic [DATA_W-1:0] max_a;
    logic [DATA_W-1:0] max_b;

    modport master (
        output start, num_samples, in_valid, a_in, b_in, p_approx,
        input  busy, done, err_count, sum_ed, max_ed, max_a, max_b
    );

    modport slave (
        input  start, num_samples, in_valid, a_in, b_in, p_approx,
        output busy, done, err_count, sum_ed, max_ed, max_a, max_b
    );
endinterface

// File: rtl/exact_mult_ref.sv
// First pipeline stage: exact unsigned product alongside the delayed operands and approximate product.
module exact_mult_ref
    import approx_mon_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned P_W    = P_W_DEF
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [P_W-1:0]    p_approx,
    output logic              out_valid,
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] b_q,
    output logic [P_W-1:0]    p_approx_q,
    output logic [P_W-1:0]    exact_q
);

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            p_approx_q <= '0;
            exact_q    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                a_q        <= a;
                b_q        <= b;
                p_approx_q <= p_approx;
                exact_q    <= P_W'(a) * P_W'(b);
            end
        end
    end

endmodule

// File: rtl/approx_error_monitor.sv
// Windowed error statistics of an approximate multiplier against an exact reference.
module approx_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned P_W    = P_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input logic                  clk_100M,
    input logic                  rst,
    approx_error_monitor_if.slave mon
);

    mon_state_e        state, state_nxt;
    logic [CNT_W-1:0]  n_lat, acc_cnt;
    logic              start_ok_c, accept_c, last_c;

    logic              v0;
    logic [DATA_W-1:0] a0, b0;
    logic [P_W-1:0]    p0, ex0;

    logic              v1, nz1;
    logic [DATA_W-1:0] a1, b1;
    logic [P_W-1:0]    ed1;

    logic              busy_q, done_q;
    logic [CNT_W-1:0]  err_count_q;
    logic [ACC_W-1:0]  sum_ed_q;
    logic [P_W-1:0]    max_ed_q;
    logic [DATA_W-1:0] max_a_q, max_b_q;

    assign start_ok_c = mon.start && ((state == IDLE) || (state == DONE));
    assign accept_c   = mon.in_valid && (state == RUN);
    assign last_c     = accept_c && ((acc_cnt + CNT_W'(1)) == n_lat);

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // DRAIN exits on the edge that retires the last sample from the final stage.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (mon.start) state_nxt = (mon.num_samples == '0) ? DONE : RUN;
            RUN:        if (last_c)    state_nxt = DRAIN;
            DRAIN:      if (!v0)       state_nxt = DONE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            n_lat   <= '0;
            acc_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (start_ok_c) begin
                n_lat   <= mon.num_samples;
                acc_cnt <= '0;
            end else if (accept_c) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            busy_q <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done_q <= (state_nxt == DONE);
        end
    end

    exact_mult_ref #(.DATA_W(DATA_W), .P_W(P_W)) u_ref (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .in_valid   (accept_c),
        .a          (mon.a_in),
        .b          (mon.b_in),
        .p_approx   (mon.p_approx),
        .out_valid  (v0),
        .a_q        (a0),
        .b_q        (b0),
        .p_approx_q (p0),
        .exact_q    (ex0)
    );

    // Error distance stage.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            nz1 <= 1'b0;
            ed1 <= '0;
            a1  <= '0;
            b1  <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                ed1 <= (ex0 >= p0) ? (ex0 - p0) : (p0 - ex0);
                nz1 <= (ex0 != p0);
                a1  <= a0;
                b1  <= b0;
            end
        end
    end

    // Accumulation stage; strict compare keeps the earliest sample on ties.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            max_a_q     <= '0;
            max_b_q     <= '0;
        end else if (start_ok_c) begin
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            max_a_q     <= '0;
            max_b_q     <= '0;
        end else if (v1) begin
            err_count_q <= err_count_q + CNT_W'(nz1);
            sum_ed_q    <= ACC_W'(sat_add(SAT_W'(sum_ed_q), SAT_W'(ed1), ACC_W));
            if (ed1 > max_ed_q) begin
                max_ed_q <= ed1;
                max_a_q  <= a1;
                max_b_q  <= b1;
            end
        end
    end

    assign mon.busy      = busy_q;
    assign mon.done      = done_q;
    assign mon.err_count = err_count_q;
    assign mon.sum_ed    = sum_ed_q;
    assign mon.max_ed    = max_ed_q;
    assign mon.max_a     = max_a_q;
    assign mon.max_b     = max_b_q;

endmodule

// File: doc/approx_error_monitor.md
Name: approx_error_monitor

Overview:
Downstream consumer of the registered 8x8 approximate-multiplier stage. It receives operand pairs together with the approximate product and computes the exact product internally. Over a programmed window of N samples it accumulates error statistics: error count, sum of error distance, and maximum error distance with its operands. Results are held for readout by the test/characterisation logic.

Parameters:
DATA_W, 8, operand width
P_W, 16, product width (2*DATA_W)
CNT_W, 16, sample-counter and error-count width
ACC_W, 32, sum-of-error-distance accumulator width

Ports:
clk_100M  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a new measurement window (sampled in IDLE or DONE)
num_samples  in  CNT_W  window length; latched on accepted start
in_valid  in  1  sample qualifier
a_in  in  DATA_W  operand A, same-cycle aligned with p_approx
b_in  in  DATA_W  operand B
p_approx  in  P_W  approximate product for (a_in, b_in)
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE, held until next accepted start
err_count  out  CNT_W  samples with nonzero error distance
sum_ed  out  ACC_W  saturating sum of |exact - p_approx|
max_ed  out  P_W  largest error distance seen
max_a  out  DATA_W  a_in of first sample reaching max_ed
max_b  out  DATA_W  b_in of that sample

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk_100M. All outputs, counters, pipeline valids and state go to 0/IDLE. Reset in any state aborts the window and discards pending results.
- States:
  - IDLE: start=1 latches num_samples, clears all result registers and accept counter -> RUN; num_samples=0 -> DONE directly, results 0.
  - RUN: each edge with in_valid=1 accepts one sample and increments the accept counter. The edge accepting sample number num_samples -> DRAIN.
  - DRAIN: wait until pipeline valids are empty -> DONE.
  - DONE: done=1, results stable. start=1 behaves as in IDLE.
- in_valid is ignored outside RUN; start is ignored in RUN and DRAIN.
- Pipeline, where E0 is the accepting edge:
  - E0: register a, b, p_approx and exact = a*b (P_W, unsigned).
  - E1: register ed = |exact - p_approx| (P_W) and nz = (ed != 0).
  - E2: update accumulators.
  - done is high after E2 of the last sample; busy falls at the same edge.
- Accumulation on E2:
  - err_count += nz.
  - sum_ed += ed, clamping to all-ones on overflow and staying clamped.
  - If ed > max_ed (strict), update max_ed, max_a and max_b; ties keep the earlier sample.
- Back-to-back in_valid every cycle is supported with no stalls; gaps are allowed.

Decomposition:
- Package approx_mon_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default width localparams;
  - saturating-add helper function.
- Sub-module exact_mult_ref holds the registered unsigned reference multiplier plus the operand/approx delay (stage E0), with a valid in/out.

Test Plan:
1. num_samples=4; samples (3,5,15), (10,10,100), (255,255,65025), (7,8,50) back-to-back -> err_count=1, sum_ed=6, max_ed=6, max_a=7, max_b=8; done high 2 edges after the 4th accept.
2. start with num_samples=0 -> DONE on the next edge; done=1, all results 0, busy never high.
3. num_samples=3, in_valid every other cycle with (255,255,0), (0,0,0), (200,200,40000) -> max_ed=65025, max_a=255, max_b=255, sum_ed=65025, err_count=1. One extra in_valid after the 3rd accept is ignored.
4. Tie handling: (2,2,0), then (4,1,0) -> max_ed=4, max_a=2, max_b=2.
5. rst pulsed mid-RUN after 2 accepts -> all outputs 0 and busy=0 immediately. A new window (1,1,0), N=1 -> err_count=1, sum_ed=1.
6. ACC_W=16 override, N=2, both samples (255,255,0) -> sum_ed=65535 saturated, err_count=2.
